// File: rtl/system_types_pkg.sv
// Shared types for the instruction-side translation path: Sv32 PTE layout,
// ITLB sizing, entry formats and the miss-handler state encoding.
package system_types_pkg;

  localparam int unsigned ITLB_4KBPAGE_ENTRIES = 16;
  localparam int unsigned ITLB_4KBPAGE_ASSOC   = 4;
  localparam int unsigned ITLB_4KBPAGE_SETS    = ITLB_4KBPAGE_ENTRIES / ITLB_4KBPAGE_ASSOC;
  localparam int unsigned ITLB_4MBPAGE_ENTRIES = 4;
  localparam int unsigned ITLB_4MBPAGE_ASSOC   = 2;
  localparam int unsigned ITLB_4MBPAGE_SETS    = ITLB_4MBPAGE_ENTRIES / ITLB_4MBPAGE_ASSOC;

  // Bit position of G inside the {D,A,G,U,X,W,R,V} permission byte
  localparam int unsigned PERM_G = 5;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic        valid;
    logic [17:0] tag;
    logic [8:0]  asid;
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [7:0]  perms;
  } itlb_4kb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [8:0]  tag;
    logic [8:0]  asid;
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [7:0]  perms;
  } itlb_4mb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } itlb_miss_state_t;

endpackage

// File: rtl/plru_4way.sv
// Tree pseudo-LRU for one 4-way set. Bit 0 picks the pair, bits 1/2 pick the
// way inside the lower/upper pair; every bit points at the next victim.
module plru_4way (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_update,
  input  logic [1:0] i_way,
  output logic [1:0] o_victim
);

  logic [2:0] r_tree;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tree <= '0;
    end else if (i_update) begin
      r_tree[0] <= ~i_way[1];
      if (i_way[1]) r_tree[2] <= ~i_way[0];
      else          r_tree[1] <= ~i_way[0];
    end
  end

  always_comb begin
    o_victim = r_tree[0] ? {1'b1, r_tree[2]} : {1'b0, r_tree[1]};
  end

endmodule

// File: rtl/itlb.sv
// Instruction TLB: parallel 4KB (4x4) and 4MB (2x2) arrays, registered lookup
// response, single outstanding L2 TLB miss, and filtered sfence invalidation.
module itlb
  import system_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        core_req_valid,
  input  logic [8:0]  core_req_ASID,
  input  logic [19:0] core_req_VPN,
  output logic        core_resp_valid,
  output logic        core_resp_hit,
  output logic [21:0] core_resp_PPN,
  output logic        core_resp_superpage,
  output logic [7:0]  core_resp_perms,
  output logic        l2_req_valid,
  input  logic        l2_req_ready,
  output logic [8:0]  l2_req_ASID,
  output logic [19:0] l2_req_VPN,
  input  logic        l2_resp_valid,
  input  logic [8:0]  l2_resp_ASID,
  input  logic [19:0] l2_resp_VPN,
  input  logic [31:0] l2_resp_pte,
  input  logic        l2_resp_superpage,
  input  logic        sfence_valid,
  input  logic        sfence_inv_ASID_en,
  input  logic [8:0]  sfence_ASID,
  input  logic        sfence_inv_VA_en,
  input  logic [19:0] sfence_VPN
);

  localparam int unsigned S4K = ITLB_4KBPAGE_SETS;
  localparam int unsigned W4K = ITLB_4KBPAGE_ASSOC;
  localparam int unsigned S4M = ITLB_4MBPAGE_SETS;
  localparam int unsigned W4M = ITLB_4MBPAGE_ASSOC;

  itlb_4kb_entry_t  r_e4k [S4K][W4K];
  itlb_4mb_entry_t  r_e4m [S4M][W4M];
  logic [S4M-1:0]   r_plru4m;
  itlb_miss_state_t r_state;
  logic             r_flush_pending;
  logic [8:0]       r_miss_asid;
  logic [19:0]      r_miss_vpn;
  logic             r_resp_valid;
  logic             r_resp_hit;
  logic [21:0]      r_resp_ppn;
  logic             r_resp_sp;
  logic [7:0]       r_resp_perms;

  logic [1:0]       w_lk_set4k;
  logic             w_lk_set4m;
  logic             w_hit4k;
  logic             w_hit4m;
  logic [1:0]       w_hit4k_way;
  logic             w_hit4m_way;

  pte_t             w_pte;
  logic             w_unused;
  logic [1:0]       w_fill_set4k;
  logic             w_fill_set4m;
  logic             w_fill;
  logic             w_fill4k;
  logic             w_fill4m;
  logic [1:0]       w_fill4k_way;
  logic             w_fill4m_way;
  logic             w_inv_found4k;
  logic             w_inv_found4m;
  itlb_4kb_entry_t  w_new4k;
  itlb_4mb_entry_t  w_new4m;

  logic [S4K-1:0]   w_upd4k;
  logic [1:0]       w_updway4k [S4K];
  logic [1:0]       w_victim4k [S4K];

  assign w_lk_set4k   = core_req_VPN[1:0];
  assign w_lk_set4m   = core_req_VPN[10];
  assign w_pte        = pte_t'(l2_resp_pte);
  assign w_unused     = ^w_pte.rsw;
  assign w_fill_set4k = l2_resp_VPN[1:0];
  assign w_fill_set4m = l2_resp_VPN[10];

  // Lookup: lowest matching way wins within each array
  always_comb begin
    w_hit4k     = 1'b0;
    w_hit4k_way = '0;
    for (int unsigned w = 0; w < W4K; w++) begin
      if (!w_hit4k && r_e4k[w_lk_set4k][w].valid &&
          r_e4k[w_lk_set4k][w].tag == core_req_VPN[19:2] &&
          (r_e4k[w_lk_set4k][w].perms[PERM_G] || r_e4k[w_lk_set4k][w].asid == core_req_ASID)) begin
        w_hit4k     = 1'b1;
        w_hit4k_way = 2'(w);
      end
    end
    w_hit4m     = 1'b0;
    w_hit4m_way = '0;
    for (int unsigned w = 0; w < W4M; w++) begin
      if (!w_hit4m && r_e4m[w_lk_set4m][w].valid &&
          r_e4m[w_lk_set4m][w].tag == core_req_VPN[19:11] &&
          (r_e4m[w_lk_set4m][w].perms[PERM_G] || r_e4m[w_lk_set4m][w].asid == core_req_ASID)) begin
        w_hit4m     = 1'b1;
        w_hit4m_way = 1'(w);
      end
    end
  end

  // A same-cycle sfence or an earlier sfence during the miss makes the fill stale
  assign w_fill   = (r_state == WAIT) && l2_resp_valid && w_pte.v &&
                    !r_flush_pending && !sfence_valid;
  assign w_fill4k = w_fill && !l2_resp_superpage;
  assign w_fill4m = w_fill && l2_resp_superpage;

  always_comb begin
    w_fill4k_way  = w_victim4k[w_fill_set4k];
    w_inv_found4k = 1'b0;
    for (int unsigned w = 0; w < W4K; w++) begin
      if (!w_inv_found4k && !r_e4k[w_fill_set4k][w].valid) begin
        w_inv_found4k = 1'b1;
        w_fill4k_way  = 2'(w);
      end
    end
    w_fill4m_way  = r_plru4m[w_fill_set4m];
    w_inv_found4m = 1'b0;
    for (int unsigned w = 0; w < W4M; w++) begin
      if (!w_inv_found4m && !r_e4m[w_fill_set4m][w].valid) begin
        w_inv_found4m = 1'b1;
        w_fill4m_way  = 1'(w);
      end
    end
  end

  always_comb begin
    w_new4k = '{valid: 1'b1, tag: l2_resp_VPN[19:2], asid: l2_resp_ASID,
                ppn1: w_pte.ppn1, ppn0: w_pte.ppn0, perms: l2_resp_pte[7:0]};
    w_new4m = '{valid: 1'b1, tag: l2_resp_VPN[19:11], asid: l2_resp_ASID,
                ppn1: w_pte.ppn1, ppn0: w_pte.ppn0, perms: l2_resp_pte[7:0]};
  end

  function automatic logic sf_match4k(input itlb_4kb_entry_t e, input logic [1:0] s);
    sf_match4k = e.valid &&
                 (!sfence_inv_ASID_en || (!e.perms[PERM_G] && e.asid == sfence_ASID)) &&
                 (!sfence_inv_VA_en || (s == sfence_VPN[1:0] && e.tag == sfence_VPN[19:2]));
  endfunction

  function automatic logic sf_match4m(input itlb_4mb_entry_t e, input logic s);
    sf_match4m = e.valid &&
                 (!sfence_inv_ASID_en || (!e.perms[PERM_G] && e.asid == sfence_ASID)) &&
                 (!sfence_inv_VA_en || (s == sfence_VPN[10] && e.tag == sfence_VPN[19:11]));
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned s = 0; s < S4K; s++)
        for (int unsigned w = 0; w < W4K; w++)
          r_e4k[s][w] <= '0;
      for (int unsigned s = 0; s < S4M; s++)
        for (int unsigned w = 0; w < W4M; w++)
          r_e4m[s][w] <= '0;
    end else begin
      for (int unsigned s = 0; s < S4K; s++)
        for (int unsigned w = 0; w < W4K; w++)
          if (sfence_valid && sf_match4k(r_e4k[s][w], 2'(s)))
            r_e4k[s][w].valid <= 1'b0;
          else if (w_fill4k && w_fill_set4k == 2'(s) && w_fill4k_way == 2'(w))
            r_e4k[s][w] <= w_new4k;
      for (int unsigned s = 0; s < S4M; s++)
        for (int unsigned w = 0; w < W4M; w++)
          if (sfence_valid && sf_match4m(r_e4m[s][w], 1'(s)))
            r_e4m[s][w].valid <= 1'b0;
          else if (w_fill4m && w_fill_set4m == 1'(s) && w_fill4m_way == 1'(w))
            r_e4m[s][w] <= w_new4m;
    end
  end

  // Fill and hit may touch the same set in one cycle; the fill owns the update
  always_comb begin
    w_upd4k = '0;
    for (int unsigned s = 0; s < S4K; s++) begin
      w_updway4k[s] = w_hit4k_way;
      if (w_fill4k && w_fill_set4k == 2'(s)) begin
        w_upd4k[s]    = 1'b1;
        w_updway4k[s] = w_fill4k_way;
      end else if (core_req_valid && w_hit4k && w_lk_set4k == 2'(s)) begin
        w_upd4k[s]    = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < S4K; g++) begin : g_plru4k
    plru_4way u_plru (
      .i_clk    (CLK),
      .i_rst_n  (nRST),
      .i_update (w_upd4k[g]),
      .i_way    (w_updway4k[g]),
      .o_victim (w_victim4k[g])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_plru4m <= '0;
    end else begin
      for (int unsigned s = 0; s < S4M; s++)
        if (w_fill4m && w_fill_set4m == 1'(s))
          r_plru4m[s] <= ~w_fill4m_way;
        else if (core_req_valid && w_hit4m && w_lk_set4m == 1'(s))
          r_plru4m[s] <= ~w_hit4m_way;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_sp    <= 1'b0;
      r_resp_ppn   <= '0;
      r_resp_perms <= '0;
    end else begin
      r_resp_valid <= core_req_valid;
      r_resp_hit   <= core_req_valid && (w_hit4k || w_hit4m);
      r_resp_sp    <= core_req_valid && !w_hit4k && w_hit4m;
      if (core_req_valid && w_hit4k) begin
        r_resp_ppn   <= {r_e4k[w_lk_set4k][w_hit4k_way].ppn1, r_e4k[w_lk_set4k][w_hit4k_way].ppn0};
        r_resp_perms <= r_e4k[w_lk_set4k][w_hit4k_way].perms;
      end else if (core_req_valid && w_hit4m) begin
        r_resp_ppn   <= {r_e4m[w_lk_set4m][w_hit4m_way].ppn1, core_req_VPN[9:0]};
        r_resp_perms <= r_e4m[w_lk_set4m][w_hit4m_way].perms;
      end else begin
        r_resp_ppn   <= '0;
        r_resp_perms <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state         <= IDLE;
      r_flush_pending <= 1'b0;
      r_miss_asid     <= '0;
      r_miss_vpn      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (core_req_valid && !w_hit4k && !w_hit4m) begin
            r_miss_asid <= core_req_ASID;
            r_miss_vpn  <= core_req_VPN;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (sfence_valid) r_flush_pending <= 1'b1;
          if (l2_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (l2_resp_valid) begin
            r_state         <= IDLE;
            r_flush_pending <= 1'b0;
          end else if (sfence_valid) begin
            r_flush_pending <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_resp_valid     = r_resp_valid;
  assign core_resp_hit       = r_resp_hit;
  assign core_resp_PPN       = r_resp_ppn;
  assign core_resp_superpage = r_resp_sp;
  assign core_resp_perms     = r_resp_perms;
  assign l2_req_valid        = (r_state == REQ);
  assign l2_req_ASID         = r_miss_asid;
  assign l2_req_VPN          = r_miss_vpn;

endmodule
